// File: rtl/conv2_pkg.sv
// Shared state encoding and geometry helpers for the conv2 layer scheduler.
package conv2_pkg;

  // Pass sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_COMMIT = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Default square kernel size and its tap count.
  localparam int CONV2_K    = 5;
  localparam int CONV2_TAPS = CONV2_K * CONV2_K;

  // Width of the tap index port (holds 1..TAPS).
  localparam int TAP_W = 5;

  // Output-map extent of a valid (unpadded) convolution along one axis.
  function automatic int out_dim(input int img, input int k);
    return img - k + 1;
  endfunction

  // Number of taps in a k x k window.
  function automatic int taps_of(input int k);
    return k * k;
  endfunction

endpackage

// File: rtl/conv2_addr_gen.sv
// Address generation: input-map pixel address for the current tap and
// output-map address for the current window.
module conv2_addr_gen
  import conv2_pkg::*;
#(
  parameter int IMG_W  = 14,
  parameter int K      = CONV2_K,
  parameter int ADDR_W = 8,
  parameter int KW     = 3
) (
  input  logic [ADDR_W-1:0] row_i,
  input  logic [ADDR_W-1:0] col_i,
  input  logic [KW-1:0]     ky_i,
  input  logic [KW-1:0]     kx_i,
  output logic [ADDR_W-1:0] pix_addr_o,
  output logic [ADDR_W-1:0] out_addr_o
);

  localparam int OUT_W = out_dim(IMG_W, K);

  // Row-major addresses, evaluated modulo 2**ADDR_W (the geometry never wraps).
  always_comb begin
    pix_addr_o = (row_i + ADDR_W'(ky_i)) * ADDR_W'(IMG_W) + col_i + ADDR_W'(kx_i);
    out_addr_o = row_i * ADDR_W'(OUT_W) + col_i;
  end

endmodule

// File: rtl/conv2_sched.sv
// Conv2 layer scheduler: walks every output window and every kernel tap,
// driving weight fetch, MAC control and output commit strobes.
module conv2_sched
  import conv2_pkg::*;
#(
  parameter int IMG_W  = 14,
  parameter int IMG_H  = 14,
  parameter int K      = CONV2_K,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              start,
  input  logic              ready,
  output logic              busy,
  output logic              done,
  output logic              w_en,
  output logic [TAP_W-1:0]  tap,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              acc_clr,
  output logic              acc_last,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr
);

  localparam int OUT_W = out_dim(IMG_W, K);
  localparam int OUT_H = out_dim(IMG_H, K);
  localparam int KW    = (K > 1) ? $clog2(K) : 1;

  state_e            state_q;
  logic [ADDR_W-1:0] row_q;
  logic [ADDR_W-1:0] col_q;
  logic [KW-1:0]     ky_q;
  logic [KW-1:0]     kx_q;

  logic run_s;
  logic commit_s;
  logic kx_end_s;
  logic ky_end_s;
  logic col_end_s;
  logic row_end_s;

  assign run_s     = (state_q == ST_RUN);
  assign commit_s  = (state_q == ST_COMMIT);
  assign kx_end_s  = (kx_q == KW'(K - 1));
  assign ky_end_s  = (ky_q == KW'(K - 1));
  assign col_end_s = (col_q == ADDR_W'(OUT_W - 1));
  assign row_end_s = (row_q == ADDR_W'(OUT_H - 1));

  // Pass sequencer: state plus window/tap counters, all frozen while ready is low.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      ky_q    <= '0;
      kx_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_RUN;
            row_q   <= '0;
            col_q   <= '0;
            ky_q    <= '0;
            kx_q    <= '0;
          end
        end
        ST_RUN: begin
          if (ready) begin
            if (kx_end_s) begin
              kx_q <= '0;
              if (ky_end_s) begin
                // Last tap of the window: park the kernel counters for the next window.
                ky_q    <= '0;
                state_q <= ST_COMMIT;
              end else begin
                ky_q <= ky_q + KW'(1);
              end
            end else begin
              kx_q <= kx_q + KW'(1);
            end
          end
        end
        ST_COMMIT: begin
          if (ready) begin
            if (col_end_s) begin
              col_q <= '0;
              if (row_end_s) begin
                row_q   <= '0;
                state_q <= ST_DONE;
              end else begin
                row_q   <= row_q + ADDR_W'(1);
                state_q <= ST_RUN;
              end
            end else begin
              col_q   <= col_q + ADDR_W'(1);
              state_q <= ST_RUN;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Strobes are decoded straight from state and ready so the ROM and MAC see them in the tap cycle.
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign w_en      = run_s & ready;
  assign acc_clr   = run_s & ready & (ky_q == '0) & (kx_q == '0);
  assign acc_last  = run_s & ready & ky_end_s & kx_end_s;
  assign out_valid = commit_s & ready;
  assign tap       = run_s ? (TAP_W'(ky_q) * TAP_W'(K) + TAP_W'(kx_q) + TAP_W'(1)) : TAP_W'(0);

  conv2_addr_gen #(
    .IMG_W  (IMG_W),
    .K      (K),
    .ADDR_W (ADDR_W),
    .KW     (KW)
  ) u_addr_gen (
    .row_i      (row_q),
    .col_i      (col_q),
    .ky_i       (ky_q),
    .kx_i       (kx_q),
    .pix_addr_o (pix_addr),
    .out_addr_o (out_addr)
  );

endmodule

// File: tb/tb_conv2_sched.sv
// Self-checking bench for conv2_sched: directed vector table, multi-cycle
// corner sequences and randomized ready/start against a step-list model.
module tb_conv2_sched;

  localparam int IMG_W   = 14;
  localparam int IMG_H   = 14;
  localparam int K       = 5;
  localparam int ADDR_W  = 8;
  localparam int OUT_W   = IMG_W - K + 1;
  localparam int OUT_H   = IMG_H - K + 1;
  localparam int TAPS    = K * K;
  localparam int WIN_CYC = TAPS + 1;
  localparam int NSTEPS  = OUT_W * OUT_H * WIN_CYC;

  logic clk = 1'b0;
  logic n_reset = 1'b1;
  logic start = 1'b0;
  logic ready = 1'b0;
  logic busy, done, w_en, acc_clr, acc_last, out_valid;
  logic [4:0] tap;
  logic [ADDR_W-1:0] pix_addr, out_addr;

  int errors = 0;
  int checks = 0;

  // Reference model: a pass is an ordered list of NSTEPS steps (25 taps then
  // one commit per window) followed by one done step; ready=1 consumes a step.
  bit   m_active = 1'b0;
  int   m_idx = 0;
  int   cyc_no = 0;
  int   ov_cnt = 0;
  int   done_cnt = 0;
  int   done_at = -1;
  int   last_oaddr = -1;
  int   last_pix25 = -1;
  logic cur_st = 1'b0;
  logic cur_rd = 1'b0;

  always #5 clk = ~clk;

  conv2_sched #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .K      (K),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .start     (start),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .w_en      (w_en),
    .tap       (tap),
    .pix_addr  (pix_addr),
    .acc_clr   (acc_clr),
    .acc_last  (acc_last),
    .out_valid (out_valid),
    .out_addr  (out_addr)
  );

  typedef struct {
    int   pre;
    logic st;
    logic rd;
    logic busy;
    int   tap;
    logic chk_pix;
    int   pix;
    logic clr;
    logic last;
    logic ov;
    logic chk_oa;
    int   oa;
  } vec_t;

  vec_t vt[11];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, got, exp);
    end
  endtask

  task automatic check_reset_zero(input string tag);
    check({tag, "_ctl"}, {busy, done, w_en, acc_clr, acc_last, out_valid}, 32'd0);
    check({tag, "_tap"}, tap, 32'd0);
    check({tag, "_pix"}, pix_addr, 32'd0);
    check({tag, "_oaddr"}, out_addr, 32'd0);
  endtask

  task automatic model_check();
    int w, s, r, c;
    logic e_busy, e_done, e_wen, e_clr, e_last, e_ov;
    int e_tap;
    e_busy = 1'b0; e_done = 1'b0; e_wen = 1'b0; e_clr = 1'b0; e_last = 1'b0; e_ov = 1'b0;
    e_tap = 0;
    if (m_active && n_reset) begin
      e_busy = 1'b1;
      if (m_idx == NSTEPS) begin
        e_done = 1'b1;
      end else begin
        w = m_idx / WIN_CYC;
        s = m_idx % WIN_CYC;
        r = w / OUT_W;
        c = w % OUT_W;
        if (s < TAPS) begin
          e_tap  = s + 1;
          e_wen  = cur_rd;
          e_clr  = cur_rd && (s == 0);
          e_last = cur_rd && (s == TAPS - 1);
          check("pix_addr", pix_addr, (r + s / K) * IMG_W + c + s % K);
        end else begin
          e_ov = cur_rd;
          check("out_addr", out_addr, r * OUT_W + c);
        end
      end
    end
    check("ctl", {busy, done, w_en, acc_clr, acc_last, out_valid},
          {e_busy, e_done, e_wen, e_clr, e_last, e_ov});
    check("tap", tap, e_tap);
    if (out_valid === 1'b1) begin
      ov_cnt++;
      last_oaddr = out_addr;
    end
    if (acc_last === 1'b1) last_pix25 = pix_addr;
    if (done === 1'b1) begin
      done_cnt++;
      done_at = cyc_no;
    end
  endtask

  task automatic model_update();
    if (!n_reset) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (cur_st) begin
        m_active = 1'b1;
        m_idx = 0;
        cyc_no = 0;
        ov_cnt = 0;
        done_cnt = 0;
        done_at = -1;
        last_oaddr = -1;
        last_pix25 = -1;
      end
    end else if (m_idx == NSTEPS) begin
      m_active = 1'b0;
    end else if (cur_rd) begin
      m_idx++;
    end
    cyc_no++;
  endtask

  task automatic drive(input logic st, input logic rd);
    @(negedge clk);
    start = st;
    ready = rd;
    cur_st = st;
    cur_rd = rd;
    #1;
    model_check();
  endtask

  task automatic finish_cyc();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic st, input logic rd);
    drive(st, rd);
    finish_cyc();
  endtask

  task automatic apply_reset(input string tag, input int ncyc);
    @(negedge clk);
    #2;
    n_reset = 1'b0;
    #1;
    m_active = 1'b0;
    check_reset_zero(tag);
    repeat (ncyc) cyc(1'b1, 1'b1);
    @(negedge clk);
    start = 1'b0;
    n_reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_done(input int rd_pct, input int st_pct, input int limit, input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < limit) begin
      cyc(($urandom_range(99) < st_pct), ($urandom_range(99) < rd_pct));
      n++;
    end
    if (done_cnt == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout no done within %0d cycles", tag, limit);
    end
    drive(1'b0, 1'b1);
    check({tag, "_busy_after"}, busy, 32'd0);
    finish_cyc();
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int n;
    int hold_pix;
    int hold_oa;

    //          pre st rd bsy tap cp pix clr lst ov co oa
    vt[0]  = '{  0, 0, 1, 0,  0, 1,  0, 0,  0, 0, 1,  0};
    vt[1]  = '{  0, 1, 1, 0,  0, 1,  0, 0,  0, 0, 1,  0};
    vt[2]  = '{  0, 0, 1, 1,  1, 1,  0, 1,  0, 0, 0,  0};
    vt[3]  = '{  3, 0, 1, 1,  5, 1,  4, 0,  0, 0, 0,  0};
    vt[4]  = '{  0, 0, 1, 1,  6, 1, 14, 0,  0, 0, 0,  0};
    vt[5]  = '{ 18, 0, 1, 1, 25, 1, 60, 0,  1, 0, 0,  0};
    vt[6]  = '{  0, 0, 1, 1,  0, 0,  0, 0,  0, 1, 1,  0};
    vt[7]  = '{  0, 0, 1, 1,  1, 1,  1, 1,  0, 0, 0,  0};
    vt[8]  = '{ 24, 0, 1, 1,  0, 0,  0, 0,  0, 1, 1,  1};
    vt[9]  = '{208, 0, 1, 1,  1, 1, 14, 1,  0, 0, 0,  0};
    vt[10] = '{ 24, 0, 1, 1,  0, 0,  0, 0,  0, 1, 1, 10};

    // Power-on reset, with start held high to show it is ignored under reset.
    #1 n_reset = 1'b0;
    #1 check_reset_zero("por");
    repeat (3) cyc(1'b1, 1'b1);
    @(negedge clk);
    start = 1'b0;
    n_reset = 1'b1;
    @(posedge clk);
    #1;

    // Directed first windows, then finish the unstalled pass.
    foreach (vt[i]) begin
      repeat (vt[i].pre) cyc(1'b0, 1'b1);
      drive(vt[i].st, vt[i].rd);
      check($sformatf("vec%0d_busy", i), busy, vt[i].busy);
      check($sformatf("vec%0d_tap", i), tap, vt[i].tap);
      if (vt[i].chk_pix) check($sformatf("vec%0d_pix", i), pix_addr, vt[i].pix);
      check($sformatf("vec%0d_clr", i), acc_clr, vt[i].clr);
      check($sformatf("vec%0d_last", i), acc_last, vt[i].last);
      check($sformatf("vec%0d_ov", i), out_valid, vt[i].ov);
      if (vt[i].chk_oa) check($sformatf("vec%0d_oaddr", i), out_addr, vt[i].oa);
      finish_cyc();
    end
    run_to_done(100, 0, 4000, "pass1");
    check("pass1_ov_cnt", ov_cnt, 32'd100);
    check("pass1_last_oaddr", last_oaddr, 32'd99);
    check("pass1_last_pix25", last_pix25, 32'd195);
    check("pass1_done_at", done_at, 32'd2601);
    check("pass1_done_cnt", done_cnt, 32'd1);

    // Stall 3 cycles at tap 12 and 2 cycles in commit.
    cyc(1'b1, 1'b1);
    n = 0;
    while (tap != 5'd12 && n < 100) begin cyc(1'b0, 1'b1); n++; end
    check("stall_reach_tap12", tap, 32'd12);
    hold_pix = pix_addr;
    repeat (3) begin
      drive(1'b0, 1'b0);
      check("stall_tap_hold", tap, 32'd12);
      check("stall_pix_hold", pix_addr, hold_pix);
      check("stall_wen", w_en, 32'd0);
      finish_cyc();
    end
    n = 0;
    while (tap != 5'd0 && n < 100) begin cyc(1'b0, 1'b1); n++; end
    hold_oa = out_addr;
    repeat (2) begin
      drive(1'b0, 1'b0);
      check("stall_commit_ov", out_valid, 32'd0);
      check("stall_commit_oaddr", out_addr, hold_oa);
      check("stall_commit_busy", busy, 32'd1);
      finish_cyc();
    end
    run_to_done(100, 0, 4000, "pass2");
    check("pass2_done_at", done_at, 32'd2606);
    check("pass2_ov_cnt", ov_cnt, 32'd100);

    // Start re-pulsed at tap 7 of window 40.
    cyc(1'b1, 1'b1);
    while (cyc_no < 39 * WIN_CYC + 7) cyc(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    check("repulse_tap", tap, 32'd7);
    finish_cyc();
    run_to_done(100, 0, 4000, "pass3");
    repeat (3) cyc(1'b0, 1'b1);
    check("pass3_done_at", done_at, 32'd2601);
    check("pass3_done_cnt", done_cnt, 32'd1);
    check("pass3_ov_cnt", ov_cnt, 32'd100);

    // Reset in the middle of window 55, then a fresh pass.
    cyc(1'b1, 1'b1);
    while (cyc_no < 54 * WIN_CYC + 10) cyc(1'b0, 1'b1);
    apply_reset("midrst", 2);
    repeat (5) cyc(1'b0, 1'($urandom_range(1)));
    check("midrst_idle_busy", busy, 32'd0);
    cyc(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    check("midrst_new_pix", pix_addr, 32'd0);
    check("midrst_new_tap", tap, 32'd1);
    check("midrst_new_clr", acc_clr, 32'd1);
    finish_cyc();
    run_to_done(100, 0, 4000, "pass4");
    check("pass4_done_at", done_at, 32'd2601);

    // Randomized ready and stray start pulses against the model.
    for (int p = 0; p < 2; p++) begin
      cyc(1'b1, 1'($urandom_range(1)));
      run_to_done(75, 3, 10000, $sformatf("rand%0d", p));
      check($sformatf("rand%0d_ov_cnt", p), ov_cnt, 32'd100);
      check($sformatf("rand%0d_done_cnt", p), done_cnt, 32'd1);
      check($sformatf("rand%0d_last_oaddr", p), last_oaddr, 32'd99);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv2_sched.md
CONV2_SCHED -- requirements
Module: conv2_sched

Interface
REQ-001 Parameter IMG_W, default 14, input feature-map width in pixels.
REQ-002 Parameter IMG_H, default 14, input feature-map height in pixels.
REQ-003 Parameter K, default 5, square kernel size; TAPS = K*K = 25.
REQ-004 Parameter ADDR_W, default 8, width of pix_addr and out_addr.
REQ-005 Port clk  input  1  clock; all logic on its rising edge.
REQ-006 Port n_reset  input  1  reset, asynchronous, active-low.
REQ-007 Port start  input  1  request to run one full conv2 layer pass.
REQ-008 Port ready  input  1  datapath and downstream can advance this cycle; low = stall.
REQ-009 Port busy  output  1  high from pass acceptance until the done pulse, inclusive.
REQ-010 Port done  output  1  one-cycle pulse at pass completion.
REQ-011 Port w_en  output  1  weight-fetch enable to the conv2 weight ROM; high on every advancing tap cycle.
REQ-012 Port tap  output  5  current tap index, 1..25, ky-major (tap = ky*K + kx + 1); 0 outside RUN.
REQ-013 Port pix_addr  output  ADDR_W  input-map address (row+ky)*IMG_W + (col+kx).
REQ-014 Port acc_clr  output  1  first tap of a window; MAC loads instead of accumulating.
REQ-015 Port acc_last  output  1  last tap (tap = 25) of a window.
REQ-016 Port out_valid  output  1  bias-add/commit cycle of one output pixel.
REQ-017 Port out_addr  output  ADDR_W  output address row*OUT_W + col, OUT_W = IMG_W-K+1.

Function
REQ-018 States SHALL be IDLE, RUN, COMMIT and DONE.
REQ-019 IDLE -> RUN on start=1; row, col, ky and kx load to 0.
REQ-020 In RUN with ready=1, kx SHALL increment; at kx=K-1, kx wraps to 0 and ky increments.
REQ-021 In RUN with ready=0, all counters SHALL hold, and w_en, acc_clr and acc_last SHALL be 0.
REQ-022 The RUN cycle with ready=1 and tap=25 SHALL go to COMMIT.
REQ-023 COMMIT SHALL drive out_valid = ready; with ready=0 it holds in COMMIT.
REQ-024 A COMMIT cycle with ready=1 SHALL advance col; at col=OUT_W-1, col wraps to 0 and row increments; the next state is RUN.
REQ-025 A COMMIT cycle with ready=1 at row=OUT_H-1 and col=OUT_W-1 (OUT_H = IMG_H-K+1) SHALL go to DONE instead of RUN.
REQ-026 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-027 start while busy=1 SHALL be ignored; it is not queued.
REQ-028 w_en, tap, pix_addr, acc_clr, acc_last, out_valid and out_addr SHALL be combinational from state, counters and ready; the weight ROM sees w_en in the same cycle as tap.
REQ-029 pix_addr and out_addr SHALL be unsigned and truncated to ADDR_W; the parameter range guarantees no overflow (IMG_W*IMG_H <= 2**ADDR_W).
REQ-030 Cycles per window with ready held high = TAPS+1 = 26; done SHALL occur 2601 cycles after the start-sampling edge.

Reset
REQ-031 n_reset low SHALL force IDLE and clear row, col, ky and kx to 0, including mid-pass.
REQ-032 During reset, busy, done, w_en, acc_clr, acc_last and out_valid SHALL be 0; tap, pix_addr and out_addr SHALL be 0.
REQ-033 After reset release, no pass SHALL resume without a new start.

Structure
REQ-034 Package conv2_pkg SHALL hold the state enum, K, TAPS and the OUT_W/OUT_H derivations.
REQ-035 Address arithmetic SHALL live in one sub-module, conv2_addr_gen, taking row/col/ky/kx and producing pix_addr and out_addr.

Verification
REQ-036 Reset, start=1 for one cycle, ready=1: tap 1 -> pix_addr 0 with acc_clr=1; tap 5 -> 4; tap 6 -> 14; tap 25 -> 60 with acc_last=1; next cycle out_valid=1, out_addr=0.
REQ-037 Second window: tap 1 -> pix_addr 1, out_addr 1 at commit; window (row 1, col 0): tap 1 -> pix_addr 14, out_addr 10.
REQ-038 Full pass with ready=1: exactly 100 out_valid pulses, last out_addr 99, last tap-25 pix_addr 195, done 2601 cycles after start, busy low the cycle after.
REQ-039 ready=0 for 3 cycles at tap 12 and for 2 cycles in COMMIT: counters and addresses hold, w_en/out_valid=0 during the stall, and the pass completes 5 cycles later than the unstalled pass.
REQ-040 start re-pulsed at tap 7 of window 40: no effect on counters; the pass completes normally with a single done pulse.
REQ-041 n_reset asserted mid-window 55: all outputs 0 at once; after release the block stays idle until start, and the new pass begins at pix_addr 0.
